// File: rtl/ramb4_s16_rd_streamer_pkg.sv
// Shared definitions for the RAMB4_S16 read streamer.
// Holds the controller state encoding and the default widths of the RAM
// 16-bit read port (word address width and data width).
// Optional feature macro used elsewhere in this slice: RDSTREAM_ABORT_EN.
package ramb4_s16_rd_streamer_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ramb4_s16_rd_streamer_skid2.sv
// rdstream_skid2: two-entry FIFO that holds RAM words until the downstream
// consumer accepts them.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears data too)
//   flush          drop all held words (data registers keep their values)
//   push/push_data write one word
//   pop            remove the head word
//   head_data      current head word (stable until popped)
//   full/empty     occupancy flags
//   count          occupancy, 0..2
// Entry 0 is always the head, so the output never moves unless popped.
module rdstream_skid2
  import ramb4_s16_rd_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem0;
  logic [DATA_W-1:0] mem1;
  logic [1:0]        cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0 <= '0;
      mem1 <= '0;
      cnt  <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            mem0 <= push_data;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            mem0 <= push_data;
          end else if (push) begin
            mem1 <= push_data;
            cnt  <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          // Full: a pop shifts entry 1 into the head; a simultaneous push
          // refills entry 1.
          if (pop) begin
            mem0 <= mem1;
            if (push) mem1 <= push_data;
            else      cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign head_data = mem0;
  assign full      = (cnt == 2'd2);
  assign empty     = (cnt == 2'd0);
  assign count     = cnt;

endmodule

// File: rtl/ramb4_s16_rd_streamer.sv
// ramb4_s16_rd_streamer: reads LEN consecutive words from a RAMB4_S16 read
// port starting at START_ADDR and presents them as a valid/ready stream.
// Ports:
//   CLK, RST            clock (also clocks the RAM port), sync active-high reset
//   START/START_ADDR/LEN command; accepted only while BUSY=0
//   BUSY, DONE          command in progress / one-cycle completion pulse
//   ADDRB, ENB, WEB, RSTB, DOB   RAM read port (WEB/RSTB tied 0)
//   DOUT, DOUT_VALID, DOUT_READY stream output
//   ABORT               only when RDSTREAM_ABORT_EN is defined
// Handshake: a word transfers on every cycle where DOUT_VALID and DOUT_READY
// are both 1; DOUT_VALID never drops and DOUT never changes until that happens.
// ENB is combinational from the registered state so a read can issue in the
// same cycle a pop frees space, which sustains one word per cycle. A read is
// issued only if the word will have a buffer slot: held words + the word on
// DOB - this cycle's pop must be below 2.
module ramb4_s16_rd_streamer
  import ramb4_s16_rd_streamer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDRB,
  output logic              ENB,
  output logic              WEB,
  output logic              RSTB,
  input  logic [DATA_W-1:0] DOB,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY
`ifdef RDSTREAM_ABORT_EN
  ,
  input  logic              ABORT
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] addrb_q;
  logic              dob_pend_q;
  logic              done_q, done_d;
  logic              issue;
  logic              pop;
  logic              push;
  logic              room;
  logic              abort_now;
  logic [1:0]        occ;
  logic              buf_full;
  logic              buf_empty;

`ifdef RDSTREAM_ABORT_EN
  assign abort_now = ABORT && (state_q != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign pop  = DOUT_VALID && DOUT_READY;
  assign room = ({1'b0, occ} + {2'b00, dob_pend_q}) < (3'd2 + {2'b00, pop});
  // The full guard never fires given the issue rule; it keeps a held word
  // from being overwritten if that rule were ever violated.
  assign push = dob_pend_q && (!buf_full || pop);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    if (abort_now) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            if (LEN == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = RUN;
              addr_d   = START_ADDR;
              remain_d = LEN;
            end
          end
        end
        RUN: begin
          if (room && (remain_q != '0)) begin
            issue    = 1'b1;
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == (ADDR_W+1)'(1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          // Final word: it is the only one held and nothing is on DOB.
          if (pop && (occ == 2'd1) && !dob_pend_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      addrb_q    <= '0;
      dob_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      dob_pend_q <= issue;
      if (issue) addrb_q <= addr_q;
    end
  end

  rdstream_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .flush     (abort_now),
    .push      (push),
    .push_data (DOB),
    .pop       (pop),
    .head_data (DOUT),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (occ)
  );

  assign ENB        = issue;
  assign ADDRB      = issue ? addr_q : addrb_q;
  assign BUSY       = (state_q != IDLE);
  assign DONE       = done_q;
  assign WEB        = 1'b0;
  assign RSTB       = 1'b0;
  assign DOUT_VALID = !buf_empty;

endmodule

// File: tb/tb_ramb4_s16_rd_streamer.sv
// Self-checking bench for ramb4_s16_rd_streamer. Build with RDSTREAM_ABORT_EN
// defined to include the abort port and its scenario.
// The reference model: each command expands into the list of words
// mem[(START_ADDR+i) mod 256], i < LEN, which must pop out in order; timing
// rules (first ENB at N+1, first valid at N+3, DONE one cycle after the last
// pop, at most two words outstanding) are checked as arithmetic on cycle counts.
module tb_ramb4_s16_rd_streamer;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          RST, START, BUSY, DONE, ENB, WEB, RSTB, DOUT_VALID, DOUT_READY;
  logic [AW-1:0] START_ADDR, ADDRB;
  logic [AW:0]   LEN;
  logic [DW-1:0] DOB, DOUT;
`ifdef RDSTREAM_ABORT_EN
  logic          ABORT;
`endif

  ramb4_s16_rd_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .RSTB(RSTB),
    .DOB(DOB), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY)
`ifdef RDSTREAM_ABORT_EN
    , .ABORT(ABORT)
`endif
  );

  // ---------------- clock / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [256];
  initial DOB = '0;
  always @(posedge clk) if (ENB) DOB <= mem[ADDRB];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int  n_checks = 0, n_pass = 0;
  int  exp_start, exp_len, exp_mode;
  int  start_cyc, last_pop_cyc, first_pop_cyc, abort_cyc;
  int  issued, popped, max_out, done_cnt = 0;
  bit  active = 0, seen_valid, done_seen, aborting = 0, prev_stall = 0;
  logic [DW-1:0] prev_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    if (prev_stall) check("stall_hold", {15'd0, DOUT_VALID, DOUT}, {15'd0, 1'b1, prev_dout});
    prev_stall = active && DOUT_VALID && !DOUT_READY;
    prev_dout  = DOUT;

    if (ENB) begin
      if (!active) check("enb_idle", 1, 0);
      else begin
        if (issued == 0) check("first_enb_lat", cyc, start_cyc + 1);
        check("addrb", ADDRB, (exp_start + issued) % 256);
        issued++;
      end
    end

    if (DOUT_VALID && active && !seen_valid) begin
      seen_valid = 1;
      check("first_valid_lat", cyc, start_cyc + 3);
    end

    if (DOUT_VALID && DOUT_READY) begin
      if (!active || exp_q.size() == 0) check("pop_extra", 1, 0);
      else begin
        check("dout", DOUT, exp_q.pop_front());
        popped++;
        if (popped == 1) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
    end

    if (active && (issued - popped) > max_out) max_out = issued - popped;

    if (DONE) begin
      done_cnt++;
      if (!active) check("done_unexpected", 1, 0);
      else if (aborting) begin
        check("abort_done_cyc", cyc, abort_cyc + 1);
        active = 0; done_seen = 1;
      end else begin
        check("done_cyc", cyc, (exp_len == 0) ? start_cyc + 1 : last_pop_cyc + 1);
        check("busy_at_done", BUSY, 0);
        check("words_left", exp_q.size(), 0);
        check("enb_count", issued, exp_len);
        check("valid_seen", seen_valid, exp_len != 0);
        check("max_outstanding", max_out <= 2, 1);
        if (exp_mode == 0 && exp_len > 0)
          check("throughput", last_pop_cyc - first_pop_cyc, exp_len - 1);
        active = 0; done_seen = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input int sa, input int len, input int mode);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(sa + i) % 256]);
    exp_start = sa; exp_len = len; exp_mode = mode;
    issued = 0; popped = 0; max_out = 0; seen_valid = 0; done_seen = 0;
    @(posedge clk); #1;
    START = 1; START_ADDR = AW'(sa); LEN = (AW+1)'(len);
    start_cyc = cyc; active = 1;
    @(posedge clk); #1;
    START = 0;
  endtask

  // mode 0: ready held 1; mode 1: ready 1,0,0,1 repeating; mode 2: random.
  // poke: fire an extra START while busy, which must be ignored.
  task automatic run_xfer(input int sa, input int len, input int mode, input bit poke);
    int k = 0;
    start_xfer(sa, len, mode);
    while (!done_seen && k < 3000) begin
      case (mode)
        0:       DOUT_READY = 1'b1;
        1:       DOUT_READY = (k % 4 == 0) || (k % 4 == 3);
        default: DOUT_READY = 1'($urandom_range(0, 1));
      endcase
      if (poke && k == 4 && BUSY) begin
        START = 1; START_ADDR = AW'($urandom); LEN = (AW+1)'($urandom_range(0, 20));
      end else START = 0;
      @(posedge clk); #1; k++;
    end
    START = 0;
    if (!done_seen) begin check("done_timeout", 0, 1); active = 0; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    int k = 0;
    int d0;
    DOUT_READY = 1;
    start_xfer(int'($urandom_range(0, 255)), 256, 0);
    while (popped < 10 && k < 500) begin @(posedge clk); #1; k++; end
    check("pops_before_rst", popped >= 10, 1);
    RST = 1;
    @(posedge clk); #1;
    RST = 0; active = 0; prev_stall = 0; exp_q.delete();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_enb", ENB, 0);
    check("rst_valid", DOUT_VALID, 0);
    check("rst_addrb", ADDRB, 0);
    check("rst_dout", DOUT, 0);
    d0 = done_cnt;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_valid", DOUT_VALID, 0);
    end
    check("no_done_after_rst", done_cnt, d0);
    run_xfer(int'($urandom_range(0, 255)), 2, 0, 0);
  endtask

`ifdef RDSTREAM_ABORT_EN
  task automatic abort_mid();
    int k = 0;
    DOUT_READY = 1;
    start_xfer(int'($urandom_range(0, 255)), 16, 0);
    while (popped < 3 && k < 100) begin @(posedge clk); #1; k++; end
    ABORT = 1; abort_cyc = cyc; aborting = 1;
    @(posedge clk); #1;
    ABORT = 0;
    check("abort_valid", DOUT_VALID, 0);
    check("abort_done", DONE, 1);
    check("abort_busy", BUSY, 0);
    k = 0;
    while (!done_seen && k < 10) begin @(posedge clk); #1; k++; end
    if (!done_seen) begin check("abort_done_timeout", 0, 1); active = 0; end
    prev_stall = 0;
    repeat (4) @(posedge clk);
    #1;
    aborting = 0;
  endtask
`endif

  // ---------------- test sequence ----------------
  initial begin
    RST = 1; START = 0; START_ADDR = '0; LEN = '0; DOUT_READY = 0;
`ifdef RDSTREAM_ABORT_EN
    ABORT = 0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'(32'h1000 + i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_enb", ENB, 0);
    check("reset_valid", DOUT_VALID, 0);
    check("reset_addrb", ADDRB, 0);
    check("reset_dout", DOUT, 0);
    check("web_rstb", {WEB, RSTB}, 0);
    RST = 0;
    @(posedge clk); #1;

    // Basic burst with known RAM contents, then address wrap.
    run_xfer(32'h10, 4, 0, 0);
    run_xfer(32'hFE, 4, 0, 0);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    run_xfer(int'($urandom_range(0, 255)), 8, 1, 0);

    // Zero-length command.
    run_xfer(int'($urandom_range(0, 255)), 0, 0, 0);

    reset_mid();

`ifdef RDSTREAM_ABORT_EN
    abort_mid();
`endif

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_xfer(int'($urandom_range(0, 255)), int'($urandom_range(1, 48)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    run_xfer(int'($urandom_range(0, 255)), 256, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ramb4_s16_rd_streamer.md
RAMB4_S16_RD_STREAMER -- requirements
Module: ramb4_s16_rd_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the RAM 16-bit read port.
REQ-002 SHALL have parameter DATA_W, default 16, read-port data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; the ports are CLK and RST.
REQ-004 SHALL have the following ports:
- CLK  in  1  rising-edge clock; also clocks the RAM read port.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle command strobe; accepted only when BUSY=0.
- START_ADDR  in  ADDR_W  first word address.
- LEN  in  ADDR_W+1  word count, 0..256.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle pulse after the last word is accepted downstream.
- ADDRB  out  ADDR_W  RAM read address.
- ENB  out  1  RAM read enable.
- WEB  out  1  tied 0.
- RSTB  out  1  tied 0.
- DOB  in  DATA_W  RAM read data; valid one cycle after an ENB=1 edge.
- DOUT  out  DATA_W  stream data.
- DOUT_VALID  out  1  stream data valid.
- DOUT_READY  in  1  downstream accepts when high together with DOUT_VALID.
- ABORT  in  1  present only under RDSTREAM_ABORT_EN.

Function
REQ-005 SHALL implement the states IDLE, RUN and DRAIN.
REQ-006 IDLE->RUN SHALL occur on START=1 with LEN>0; START_ADDR and LEN are latched, and the block goes BUSY=1 on the next cycle.
REQ-007 START with LEN=0 SHALL perform no RAM access, pulse DONE on the next cycle and remain in IDLE.
REQ-008 In RUN, a read SHALL issue (ENB=1, ADDRB=current address) only when words remaining to issue >0 and (buffer occupancy + reads in flight - pop this cycle) <2.
REQ-009 After each issued read, the address SHALL increment modulo 2^ADDR_W (255 wraps to 0) and the issue count SHALL decrement.
REQ-010 ENB SHALL be 0 on every cycle with no issued read; ADDRB holds its last value.
REQ-011 DOB SHALL be captured into a 2-entry output buffer on the cycle after each issue; no captured word is ever lost or duplicated under any DOUT_READY pattern.
REQ-012 DOUT/DOUT_VALID SHALL present the buffer head; a pop occurs when DOUT_VALID&DOUT_READY.
REQ-013 With DOUT_READY held 1, throughput SHALL be one word per cycle.
REQ-014 First-read latency SHALL be: START at cycle N, first ENB at N+1, first DOUT_VALID at N+3.
REQ-015 DOUT SHALL remain stable while DOUT_VALID=1 and DOUT_READY=0.
REQ-016 RUN->DRAIN SHALL occur when the last read issues; DRAIN->IDLE occurs on the pop of the final word.
REQ-017 DONE SHALL pulse on the cycle after the final pop; BUSY falls in the same cycle.
REQ-018 START while BUSY=1 SHALL be ignored.

Reset
REQ-019 On RST=1 at a clock edge, state SHALL go to IDLE; BUSY, DONE, ENB and DOUT_VALID become 0; ADDRB and DOUT become 0; buffer occupancy, in-flight count and counters clear.
REQ-020 RST mid-transfer SHALL discard all in-flight and buffered words; DONE does not pulse.
REQ-021 DOB returning in the cycle after reset SHALL be ignored.

Configuration
REQ-022 With RDSTREAM_ABORT_EN defined, the ABORT port SHALL exist. ABORT=1 while BUSY stops further issues and flushes the buffer and in-flight word. The block returns to IDLE with DONE pulsed on the next cycle. DOUT_VALID is 0 from the cycle after ABORT.
REQ-023 Without RDSTREAM_ABORT_EN, the port and its logic SHALL be absent and behaviour SHALL be as in REQ-005..REQ-021.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE/RUN/DRAIN) and the ADDR_W/DATA_W default constants.
REQ-025 The 2-entry output buffer SHALL be one sub-module, rdstream_skid2, with push/pop, full/empty and a data interface.

Verification
REQ-026 START_ADDR=0x10, LEN=4, DOUT_READY=1, RAM words 0x1000+i -> ENB for 4 cycles, DOUT 0x1010..0x1013 on consecutive cycles, first DOUT_VALID 3 cycles after START, DONE once.
REQ-027 START_ADDR=0xFE, LEN=4 -> ADDRB sequence FE, FF, 00, 01; four words out, in order.
REQ-028 LEN=8 with DOUT_READY toggling 1,0,0,1 repeating -> exactly 8 pops, in order, none dropped or repeated, DOUT stable while stalled, ENB never issues with 2 words outstanding.
REQ-029 LEN=0 -> DONE on the next cycle, ENB never 1, DOUT_VALID never 1.
REQ-030 LEN=256, RST asserted after 10 pops -> all outputs at reset values on the next cycle, no DONE; a new START with LEN=2 then completes normally.
REQ-031 (RDSTREAM_ABORT_EN) LEN=16, ABORT after 3 pops -> DOUT_VALID 0 on the next cycle, DONE pulses, BUSY 0, no further ENB.
